// File: rtl/gpsdo_loop_sequencer.sv
// gpsdo_loop_sequencer: acquisition/lock sequencer for the GPSDO discipline loop.
// Walks align/settle/coarse/fine/locked on each PPS phase sample, with holdover on missing PPS.
module gpsdo_loop_sequencer #(
  parameter int COARSE_TH   = 100,
  parameter int FINE_TH     = 10,
  parameter int LOCK_TH     = 1,
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_CNT  = 4,
  parameter int SETTLE_CNT  = 2,
  parameter int TIMEOUT_CYC = 12_000_000
) (
  input  logic               CLK_SYS,
  input  logic               CLK_RST,
  input  logic               Measure_Done,
  input  logic signed [24:0] Phase_Err,
  output logic               Err_Valid,
  output logic [1:0]         Gain_Sel,
  output logic               Loop_Hold,
  output logic               DIV_RST,
  output logic               Led_Lock,
  output logic               Holdover,
  output logic [2:0]         Loop_State
);
  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_SETTLE, S_COARSE, S_FINE, S_LOCKED, S_HOLDOVER
  } state_t;

  localparam logic [23:0] L_CTH = 24'(COARSE_TH);
  localparam logic [23:0] L_FTH = 24'(FINE_TH);
  localparam logic [23:0] L_LTH = 24'(LOCK_TH);
  localparam logic [23:0] L_TMO = 24'(TIMEOUT_CYC);
  localparam logic [7:0]  L_LCNT = 8'(LOCK_CNT);
  localparam logic [7:0]  L_UCNT = 8'(UNLOCK_CNT);
  localparam logic [7:0]  L_SCNT = 8'(SETTLE_CNT);

  state_t      r_state, w_next;
  logic [7:0]  r_settle, r_good, r_bad, w_settle, w_good, w_bad;
  logic [23:0] r_tmo, w_abs;
  logic [1:0]  r_gain;
  logic        r_ev, r_hold, r_div, r_led, r_hov;
  logic        w_big, w_fine, w_lock, w_expire, w_ev, w_loop;

  // the most negative error has no positive twin in 24 bits, so it saturates
  assign w_abs = Phase_Err[24] ? ((Phase_Err[23:0] == 24'd0) ? 24'hFFFFFF : 24'(-Phase_Err))
                               : Phase_Err[23:0];
  assign w_big  = w_abs > L_CTH;
  assign w_fine = w_abs <= L_FTH;
  assign w_lock = w_abs <= L_LTH;
  // a sample arriving on the expiry cycle takes priority over holdover
  assign w_expire = !Measure_Done && (r_tmo == L_TMO - 24'd1) &&
                    r_state != S_IDLE && r_state != S_HOLDOVER;
  assign w_loop = r_state == S_COARSE || r_state == S_FINE || r_state == S_LOCKED;

  always_comb begin
    w_next   = r_state;
    w_settle = r_settle;
    w_good   = r_good;
    w_bad    = r_bad;
    if (Measure_Done)
      case (r_state)
        S_IDLE: w_next = S_ALIGN;
        S_SETTLE: begin
          w_settle = r_settle + 8'd1;
          w_next   = (w_settle == L_SCNT) ? S_COARSE : S_SETTLE;
        end
        S_COARSE: begin
          w_good = '0;
          w_next = w_big ? S_ALIGN : w_fine ? S_FINE : S_COARSE;
        end
        S_FINE: begin
          w_good = w_lock ? r_good + 8'd1 : '0;
          w_bad  = '0;
          w_next = w_big ? S_ALIGN : !w_fine ? S_COARSE : (w_good == L_LCNT) ? S_LOCKED : S_FINE;
        end
        S_LOCKED: begin
          w_bad  = w_lock ? '0 : r_bad + 8'd1;
          w_good = '0;
          w_next = w_big ? S_ALIGN : (w_bad == L_UCNT) ? S_FINE : S_LOCKED;
        end
        S_HOLDOVER: begin
          w_good = '0;
          w_next = w_fine ? S_FINE : S_ALIGN;
        end
        default: ;
      endcase
    if (r_state == S_ALIGN) begin
      w_next   = S_SETTLE;
      w_settle = '0;
    end
    if (w_expire) w_next = S_HOLDOVER;
    w_ev = Measure_Done && w_loop && w_next != S_ALIGN;
  end

  always_ff @(posedge CLK_SYS) begin
    if (!CLK_RST) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_good   <= '0;
      r_bad    <= '0;
      r_tmo    <= '0;
      r_gain   <= 2'd0;
      r_ev     <= 1'b0;
      r_hold   <= 1'b1;
      r_div    <= 1'b0;
      r_led    <= 1'b0;
      r_hov    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_settle <= w_settle;
      r_good   <= w_good;
      r_bad    <= w_bad;
      r_tmo    <= (Measure_Done || r_state == S_IDLE) ? '0 : (r_tmo == L_TMO) ? r_tmo : r_tmo + 24'd1;
      r_gain   <= (w_next == S_FINE) ? 2'd1 : (w_next == S_LOCKED) ? 2'd2 :
                  (w_next == S_HOLDOVER) ? r_gain : 2'd0;
      r_ev     <= w_ev;
      r_hold   <= !(w_next == S_COARSE || w_next == S_FINE || w_next == S_LOCKED);
      r_div    <= w_next == S_ALIGN;
      r_led    <= w_next == S_LOCKED;
      r_hov    <= w_next == S_HOLDOVER;
    end
  end

  assign Err_Valid  = r_ev;
  assign Gain_Sel   = r_gain;
  assign Loop_Hold  = r_hold;
  assign DIV_RST    = r_div;
  assign Led_Lock   = r_led;
  assign Holdover   = r_hov;
  assign Loop_State = r_state;
endmodule

// File: tb/tb_gpsdo_loop_sequencer.sv
// tb_gpsdo_loop_sequencer: directed scenarios plus random PPS traffic against a
// behavioural model of the sequencer, with a short timeout to exercise holdover.
module tb_gpsdo_loop_sequencer;
  localparam int T = 1000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mdone;
  logic signed [24:0] perr;
  logic               Err_Valid, Loop_Hold, DIV_RST, Led_Lock, Holdover;
  logic [1:0]         Gain_Sel;
  logic [2:0]         Loop_State;
  logic [9:0]         obs;

  int n_vec = 0;
  int n_err = 0;
  int m_state, m_settle, m_good, m_bad, m_tmo, m_gain;
  bit m_ev;

  gpsdo_loop_sequencer #(.TIMEOUT_CYC(T)) dut (
    .CLK_SYS(clk), .CLK_RST(rst_n), .Measure_Done(mdone), .Phase_Err(perr),
    .Err_Valid(Err_Valid), .Gain_Sel(Gain_Sel), .Loop_Hold(Loop_Hold), .DIV_RST(DIV_RST),
    .Led_Lock(Led_Lock), .Holdover(Holdover), .Loop_State(Loop_State)
  );

  always #5 clk = ~clk;
  assign obs = {Err_Valid, Gain_Sel, Loop_Hold, DIV_RST, Led_Lock, Holdover, Loop_State};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // state numbers: 0 idle, 1 align, 2 settle, 3 coarse, 4 fine, 5 locked, 6 holdover
  task automatic model(input logic r, input logic md, input logic signed [24:0] e);
    int ei, a, ns;
    bit ev;
    ei = int'(e);
    a = (ei == -(1 << 24)) ? (1 << 24) - 1 : (ei < 0) ? -ei : ei;
    if (!r) begin
      m_state = 0; m_settle = 0; m_good = 0; m_bad = 0; m_tmo = 0; m_gain = 0; m_ev = 0;
      return;
    end
    ns = m_state;
    ev = 0;
    if (md) begin
      if (m_state == 0) ns = 1;
      else if (m_state == 2) begin
        m_settle++;
        if (m_settle >= 2) ns = 3;
      end else if (m_state == 3) begin
        if (a > 100) ns = 1;
        else begin
          ev = 1;
          if (a <= 10) begin ns = 4; m_good = 0; end
        end
      end else if (m_state == 4) begin
        if (a > 100) ns = 1;
        else if (a > 10) begin ns = 3; ev = 1; end
        else begin
          ev = 1;
          m_good = (a <= 1) ? m_good + 1 : 0;
          if (m_good >= 16) begin ns = 5; m_bad = 0; end
        end
      end else if (m_state == 5) begin
        if (a > 100) ns = 1;
        else begin
          ev = 1;
          m_bad = (a > 1) ? m_bad + 1 : 0;
          if (m_bad >= 4) begin ns = 4; m_good = 0; end
        end
      end else if (m_state == 6) begin
        if (a <= 10) begin ns = 4; m_good = 0; end
        else ns = 1;
      end
    end
    if (m_state == 1) begin ns = 2; m_settle = 0; end
    if (!md && m_state != 0 && m_state != 6 && m_tmo + 1 >= T) ns = 6;
    m_gain = (ns == 4) ? 1 : (ns == 5) ? 2 : (ns == 6) ? m_gain : 0;
    m_tmo = (md || m_state == 0) ? 0 : (m_tmo + 1 > T) ? T : m_tmo + 1;
    m_ev = ev;
    m_state = ns;
  endtask

  function automatic logic [9:0] exp_vec();
    logic hold;
    hold = !(m_state == 3 || m_state == 4 || m_state == 5);
    return {m_ev, 2'(m_gain), hold, m_state == 1, m_state == 5, m_state == 6, 3'(m_state)};
  endfunction

  task automatic step(input logic r, input logic md, input logic signed [24:0] e);
    @(negedge clk);
    check("cycle", 16'(obs), 16'(exp_vec()));
    rst_n = r;
    mdone = md;
    perr  = md ? e : 25'(int'($urandom_range(0, 255)));
    model(r, md, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 25'sd0);
  endtask

  task automatic smp(input int e);
    step(1'b1, 1'b1, 25'(e));
    idle(1);
  endtask

  function automatic int pm1();
    return int'($urandom_range(0, 2)) - 1;
  endfunction

  function automatic int rnd_err();
    int c, v;
    c = int'($urandom_range(0, 19));
    v = (c < 15) ? int'($urandom_range(0, 1)) : (c < 17) ? int'($urandom_range(2, 10)) :
        (c < 18) ? int'($urandom_range(11, 100)) : (c < 19) ? int'($urandom_range(101, (1 << 24) - 1)) :
        (1 << 24) - 1;
    if ($urandom_range(0, 1) == 1) v = (c == 19 && $urandom_range(0, 1) == 1) ? -(1 << 24) : -v;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; mdone = 1'b0; perr = '0;
    model(1'b0, 1'b0, 25'sd0);
    step(1'b0, 1'b0, 25'sd0);
    step(1'b1, 1'b0, 25'sd0);
    check("rst_outputs", 16'(obs), 16'({1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}));
    // acquisition: align, two discarded settle samples, coarse -> fine
    smp(500);
    check("t1_align", 16'(obs), 16'({1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1}));
    idle(1);
    check("t1_settle", 16'(obs), 16'({1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2}));
    smp(300);
    smp(300);
    check("t1_coarse", 16'(Loop_State), 16'd3);
    smp(5);
    check("t1_fine", 16'(obs), 16'({1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4}));
    for (int i = 0; i < 15; i++) smp(pm1());
    smp(3);
    check("t2_no_lock", 16'(Loop_State), 16'd4);
    for (int i = 0; i < 15; i++) smp(pm1());
    check("t2_15_good", 16'(Loop_State), 16'd4);
    smp(pm1());
    check("t2_locked", 16'(obs), 16'({1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5}));
    for (int i = 0; i < 3; i++) smp(4);
    smp(0);
    check("t3_hold_lock", 16'(Loop_State), 16'd5);
    for (int i = 0; i < 4; i++) smp(-4);
    check("t3_unlock", 16'({Led_Lock, Gain_Sel, Loop_State}), 16'({1'b0, 2'd1, 3'd4}));
    for (int i = 0; i < 16; i++) smp(0);
    smp(-150);
    check("t4_align", 16'(obs), 16'({1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1}));
    idle(1);
    check("t4_settle", 16'({DIV_RST, Loop_State}), 16'({1'b0, 3'd2}));
    smp(0); smp(0); smp(0);
    for (int i = 0; i < 16; i++) smp(0);
    idle(T);
    check("t5_holdover", 16'(obs), 16'({1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6}));
    smp(2);
    check("t5_exit_fine", 16'({Err_Valid, Gain_Sel, Loop_State}), 16'({1'b0, 2'd1, 3'd4}));
    idle(T);
    check("t5_holdover2", 16'({Gain_Sel, Loop_State}), 16'({2'd1, 3'd6}));
    smp(50);
    check("t5_exit_align", 16'({DIV_RST, Loop_State}), 16'({1'b1, 3'd1}));
    idle(1);
    smp(9); smp(9); smp(100);
    check("t6_coarse_edge", 16'(Loop_State), 16'd3);
    smp(10);
    step(1'b1, 1'b1, 25'sd0);
    idle(T - 1);
    step(1'b1, 1'b1, 25'sd0);
    idle(1);
    check("t6_no_holdover", 16'({Holdover, Loop_State}), 16'({1'b0, 3'd4}));
    smp(-5);
    smp(-(1 << 24));
    check("t6_min_err", 16'(Loop_State), 16'd1);
    idle(1);
    smp(0);
    step(1'b0, 1'b0, 25'sd0);
    idle(1);
    check("t6_mid_reset", 16'(obs), 16'({1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}));
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 799) == 0) idle(int'($urandom_range(T - 10, T + 10)));
      step(1'b1 ^ ($urandom_range(0, 2999) == 0), $urandom_range(0, 3) == 0, 25'(rnd_err()));
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
